ysyx_bus_arb: RTL and testbench
===============================

Name: ysyx_bus_arb

Overview:
Single-master memory-bus arbiter that shares one AXI4-Lite-style port between the IFU instruction fetch/L1I refill channel and the LSU load/store channel. It grants one transaction at a time and registers address and write data at grant. It routes the response back only to the owner. It keeps IFU line refills atomic: an IFU multi-beat refill holds the bus via ifu_required_o. Sits between ysyx_ifu / ysyx_lsu and the SoC crossbar.

Parameters:
DATA_W, 32, address and data width
STARVE_MAX, 4, consecutive LSU grants while IFU is waiting before IFU is forced next

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low (0 = reset)
ifu_araddr  input  DATA_W  IFU read address
ifu_arvalid  input  1  IFU read request
ifu_required  input  1  IFU refill in progress; lock bus to IFU
ifu_rdata  output  DATA_W  read data to IFU
ifu_rvalid  output  1  read beat valid for IFU
lsu_araddr  input  DATA_W  LSU read address
lsu_arvalid  input  1  LSU read request
lsu_awaddr  input  DATA_W  LSU write address
lsu_awvalid  input  1  LSU write request
lsu_wdata  input  DATA_W  LSU write data
lsu_wstrb  input  DATA_W/8  LSU byte strobes
lsu_rdata  output  DATA_W  read data to LSU
lsu_rvalid  output  1  read beat valid for LSU
lsu_bvalid  output  1  write complete to LSU
bus_araddr/bus_arvalid  output  DATA_W/1  read address channel
bus_arready  input  1
bus_rdata/bus_rvalid  input  DATA_W/1  read data channel
bus_rready  output  1
bus_awaddr/bus_awvalid  output  DATA_W/1  write address channel
bus_awready  input  1
bus_wdata/bus_wstrb/bus_wvalid  output  DATA_W/DATA_W/8/1  write data channel
bus_wready  input  1
bus_bvalid  input  1  write response
bus_bready  output  1
grant_ifu_o  output  1  IFU owns bus (any state other than IDLE, IFU-owned)

Behaviour:
- Reset (rst=0, async): state IDLE; all bus_*valid, bus_rready, bus_bready, ifu_rvalid, lsu_rvalid, lsu_bvalid, grant_ifu_o = 0; starve counter = 0; lock = 0. Reset mid-transaction abandons it; no response is forwarded.
- States: IDLE, IFU_AR, IFU_R, LSU_AR, LSU_R, LSU_W (AW+W), LSU_B.
- IDLE arbitration, evaluated each cycle, one winner:
  1. lock=1 and ifu_arvalid -> IFU.
  2. starve counter == STARVE_MAX and ifu_arvalid -> IFU.
  3. lsu_awvalid -> LSU_W. Write beats read.
  4. lsu_arvalid -> LSU_AR.
  5. ifu_arvalid -> IFU_AR.
- Grant latches the address, data and strobe into registers. The bus valid rises the cycle after grant (registered). Minimum latency is request at cycle N, bus valid at N+1.
- IFU_AR: bus_arvalid=1 until bus_arready, then IFU_R. IFU_R: bus_rready=1; ifu_rvalid=bus_rvalid and ifu_rdata=bus_rdata, combinational pass-through. On the rvalid beat, go to IDLE.
- LSU_AR/LSU_R: same as the IFU path, routed to lsu_rdata/lsu_rvalid.
- LSU_W: bus_awvalid and bus_wvalid are raised together. Each drops independently on its own ready. Go to LSU_B when both handshakes are done, including same-cycle completion. LSU_B: bus_bready=1; lsu_bvalid pulses one cycle on bus_bvalid; then IDLE.
- Lock: set when IFU_R completes a beat with ifu_required=1. Cleared in IDLE when ifu_required=0. While lock=1, LSU requests are held off and the IFU is granted next even if ifu_arvalid arrives late.
- Starve counter: increments, saturating at STARVE_MAX, on each LSU grant while ifu_arvalid=1. Clears on any IFU grant.
- Response routing: the non-owner's rvalid/bvalid are held at 0. A bus_rvalid/bus_bvalid seen in IDLE or in a non-matching state is ignored and not acknowledged.
- Requesters hold valid and address stable until their response arrives. Dropping a request after grant does not abort the bus transaction.

Test Plan:
- IFU-only read at 0x3000_0000, bus_arready at N+2, bus_rvalid at N+4 with data 0x0000_0413 -> one ifu_rvalid pulse with 0x0000_0413; lsu_rvalid stays 0.
- Same-cycle IFU read and LSU read -> LSU_AR granted first. The IFU is granted in the cycle after the LSU rvalid returns to IDLE.
- LSU write, addr 0x8000_0010, data 0xDEAD_BEEF, strb 0xF; wready 2 cycles before awready -> wvalid drops early; lsu_bvalid pulses once after bvalid.
- IFU two-beat refill with ifu_required=1 and LSU load pending -> both IFU beats complete back-to-back. LSU is granted only after ifu_required falls.
- LSU requesting continuously with IFU waiting, STARVE_MAX=4 -> 4 LSU grants then 1 IFU grant; counter returns to 0.
- rst driven to 0 in LSU_R before rvalid -> all valids 0 immediately. After release the state is IDLE and the late bus_rvalid is ignored (lsu_rvalid=0).

Source files
------------

// File: rtl/ysyx_bus_arb.sv
// Shares one AXI4-Lite style port between the IFU fetch/refill channel and the LSU.
// One transaction in flight; responses are routed only to the current owner.
module ysyx_bus_arb #(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    input  logic                ifu_required,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rvalid,
    input  logic [DATA_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    input  logic [DATA_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rvalid,
    output logic                lsu_bvalid,
    output logic [DATA_W-1:0]   bus_araddr,
    output logic                bus_arvalid,
    input  logic                bus_arready,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_rvalid,
    output logic                bus_rready,
    output logic [DATA_W-1:0]   bus_awaddr,
    output logic                bus_awvalid,
    input  logic                bus_awready,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic                bus_wvalid,
    input  logic                bus_wready,
    input  logic                bus_bvalid,
    output logic                bus_bready,
    output logic                grant_ifu_o
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        IFU_AR,
        IFU_R,
        LSU_AR,
        LSU_R,
        LSU_W,
        LSU_B
    } state_t;

    state_t              state;
    logic [CW-1:0]       starve;
    logic                lock;
    logic                ar_v;
    logic                aw_v;
    logic                w_v;
    logic [DATA_W-1:0]   ar_a;
    logic [DATA_W-1:0]   aw_a;
    logic [DATA_W-1:0]   w_d;
    logic [DATA_W/8-1:0] w_s;

    logic starved;
    logic g_ifu;
    logic g_w;
    logic g_r;
    logic aw_done;
    logic w_done;

    assign starved = (starve == CW'(STARVE_MAX));
    assign aw_done = !aw_v || bus_awready;
    assign w_done  = !w_v || bus_wready;

    // Lock wins outright: LSU waits even when the next IFU beat is late.
    always_comb begin
        g_ifu = 1'b0;
        g_w   = 1'b0;
        g_r   = 1'b0;
        if (lock) begin
            g_ifu = ifu_arvalid;
        end else if (starved && ifu_arvalid) begin
            g_ifu = 1'b1;
        end else if (lsu_awvalid) begin
            g_w = 1'b1;
        end else if (lsu_arvalid) begin
            g_r = 1'b1;
        end else if (ifu_arvalid) begin
            g_ifu = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            starve      <= '0;
            lock        <= 1'b0;
            ar_v        <= 1'b0;
            aw_v        <= 1'b0;
            w_v         <= 1'b0;
            ar_a        <= '0;
            aw_a        <= '0;
            w_d         <= '0;
            w_s         <= '0;
            grant_ifu_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!ifu_required) lock <= 1'b0;
                    if (g_ifu) begin
                        state       <= IFU_AR;
                        ar_a        <= ifu_araddr;
                        ar_v        <= 1'b1;
                        starve      <= '0;
                        grant_ifu_o <= 1'b1;
                    end else if (g_w || g_r) begin
                        if (ifu_arvalid && !starved) starve <= starve + 1'b1;
                        if (g_w) begin
                            state <= LSU_W;
                            aw_a  <= lsu_awaddr;
                            w_d   <= lsu_wdata;
                            w_s   <= lsu_wstrb;
                            aw_v  <= 1'b1;
                            w_v   <= 1'b1;
                        end else begin
                            state <= LSU_AR;
                            ar_a  <= lsu_araddr;
                            ar_v  <= 1'b1;
                        end
                    end
                end
                IFU_AR: begin
                    if (bus_arready) begin
                        ar_v  <= 1'b0;
                        state <= IFU_R;
                    end
                end
                IFU_R: begin
                    if (bus_rvalid) begin
                        state       <= IDLE;
                        grant_ifu_o <= 1'b0;
                        if (ifu_required) lock <= 1'b1;
                    end
                end
                LSU_AR: begin
                    if (bus_arready) begin
                        ar_v  <= 1'b0;
                        state <= LSU_R;
                    end
                end
                LSU_R: begin
                    if (bus_rvalid) state <= IDLE;
                end
                LSU_W: begin
                    if (bus_awready) aw_v <= 1'b0;
                    if (bus_wready) w_v <= 1'b0;
                    if (aw_done && w_done) state <= LSU_B;
                end
                LSU_B: begin
                    if (bus_bvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus_araddr  = ar_a;
    assign bus_arvalid = ar_v;
    assign bus_awaddr  = aw_a;
    assign bus_awvalid = aw_v;
    assign bus_wdata   = w_d;
    assign bus_wstrb   = w_s;
    assign bus_wvalid  = w_v;
    assign bus_rready  = (state == IFU_R) || (state == LSU_R);
    assign bus_bready  = (state == LSU_B);

    assign ifu_rdata  = bus_rdata;
    assign lsu_rdata  = bus_rdata;
    assign ifu_rvalid = (state == IFU_R) && bus_rvalid;
    assign lsu_rvalid = (state == LSU_R) && bus_rvalid;
    assign lsu_bvalid = (state == LSU_B) && bus_bvalid;

endmodule

// File: tb/tb_ysyx_bus_arb.sv
// Scoreboard bench for ysyx_bus_arb: directed requesters, a small bus slave,
// and a negedge monitor that checks grant order, write beats and responses.
module tb_ysyx_bus_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_required;
    logic [31:0] ifu_rdata;
    logic        ifu_rvalid;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid;
    logic [31:0] lsu_awaddr;
    logic        lsu_awvalid;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic [31:0] lsu_rdata;
    logic        lsu_rvalid;
    logic        lsu_bvalid;
    logic [31:0] bus_araddr;
    logic        bus_arvalid;
    logic        bus_arready;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        bus_rready;
    logic [31:0] bus_awaddr;
    logic        bus_awvalid;
    logic        bus_awready;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_wvalid;
    logic        bus_wready;
    logic        bus_bvalid;
    logic        bus_bready;
    logic        grant_ifu_o;

    always #5 clk = ~clk;

    ysyx_bus_arb #(.DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
        .ifu_required(ifu_required),
        .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_bvalid(lsu_bvalid),
        .bus_araddr(bus_araddr), .bus_arvalid(bus_arvalid),
        .bus_arready(bus_arready),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .bus_rready(bus_rready),
        .bus_awaddr(bus_awaddr), .bus_awvalid(bus_awvalid),
        .bus_awready(bus_awready),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_wvalid(bus_wvalid), .bus_wready(bus_wready),
        .bus_bvalid(bus_bvalid), .bus_bready(bus_bready),
        .grant_ifu_o(grant_ifu_o)
    );

    typedef struct packed {
        logic        ifu;
        logic [31:0] a;
    } gnt_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    gnt_t        gq[$];
    wr_t         wq[$];
    logic [31:0] ifu_q[$];
    logic [31:0] lsu_q[$];
    int          b_exp = 0;

    int checks = 0;
    int errors = 0;

    int ar_dly = 0;
    int r_dly  = 0;
    int aw_dly = 0;
    int w_dly  = 0;
    int b_dly  = 0;

    logic prev_ar;
    logic prev_aw;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endfunction

    function automatic void unexp(string nm);
        checks++;
        errors++;
        $display("FAIL %s got unexpected beat want none", nm);
    endfunction

    function automatic logic [31:0] rd_table(logic [31:0] a);
        case (a)
            32'h3000_0000: return 32'h0000_0413;
            32'h3000_0100: return 32'h0000_0093;
            32'h3000_0104: return 32'h0010_0113;
            32'h8000_0020: return 32'h1234_5678;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    function automatic logic probe(int sel);
        case (sel)
            0:       return ifu_rvalid;
            1:       return lsu_rvalid;
            2:       return lsu_bvalid;
            3:       return bus_rready;
            default: return bus_rvalid;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int sel, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!probe(sel) && n < 300);
        if (!probe(sel)) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s got 0 want 1", nm);
        end
    endtask

    task automatic ifu_rd(input logic [31:0] a, input logic [31:0] d);
        ifu_q.push_back(d);
        ifu_araddr  = a;
        ifu_arvalid = 1'b1;
        wait_for(0, "ifu_rvalid");
        step();
        ifu_arvalid = 1'b0;
    endtask

    task automatic lsu_rd(input logic [31:0] a, input logic [31:0] d);
        lsu_q.push_back(d);
        lsu_araddr  = a;
        lsu_arvalid = 1'b1;
        wait_for(1, "lsu_rvalid");
        step();
        lsu_arvalid = 1'b0;
    endtask

    // Bus slave: one transaction at a time with per-test handshake delays.
    task automatic slave_read();
        logic [31:0] a;
        a = bus_araddr;
        repeat (ar_dly) step();
        bus_arready = 1'b1;
        step();
        bus_arready = 1'b0;
        repeat (r_dly) step();
        bus_rvalid = 1'b1;
        bus_rdata  = rd_table(a);
        step();
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
    endtask

    task automatic slave_write();
        int c   = 0;
        bit awd = 1'b0;
        bit wd  = 1'b0;
        while (!(awd && wd) && c < 100) begin
            bus_awready = !awd && (c >= aw_dly);
            bus_wready  = !wd && (c >= w_dly);
            step();
            awd = awd | bus_awready;
            wd  = wd | bus_wready;
            c++;
        end
        bus_awready = 1'b0;
        bus_wready  = 1'b0;
        repeat (b_dly) step();
        bus_bvalid = 1'b1;
        step();
        bus_bvalid = 1'b0;
    endtask

    initial begin
        bus_arready = 1'b0;
        bus_rvalid  = 1'b0;
        bus_rdata   = '0;
        bus_awready = 1'b0;
        bus_wready  = 1'b0;
        bus_bvalid  = 1'b0;
        forever begin
            step();
            if (rst === 1'b1) begin
                if (bus_arvalid) slave_read();
                else if (bus_awvalid || bus_wvalid) slave_write();
            end
        end
    end

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            prev_ar <= 1'b0;
            prev_aw <= 1'b0;
        end else begin
            if ((bus_arvalid && !prev_ar) || (bus_awvalid && !prev_aw)) begin
                if (gq.size() == 0) begin
                    unexp("grant");
                end else begin
                    chk("grant_owner", 32'(grant_ifu_o), 32'(gq[0].ifu));
                    chk("grant_addr", bus_arvalid ? bus_araddr : bus_awaddr,
                        gq[0].a);
                    void'(gq.pop_front());
                end
            end
            if (bus_wvalid && bus_wready) begin
                if (wq.size() == 0) begin
                    unexp("w_beat");
                end else begin
                    chk("wdata", bus_wdata, wq[0].d);
                    chk("wstrb", 32'(bus_wstrb), 32'(wq[0].s));
                    void'(wq.pop_front());
                end
            end
            if (ifu_rvalid) begin
                if (ifu_q.size() == 0) begin
                    unexp("ifu_rvalid");
                end else begin
                    chk("ifu_rdata", ifu_rdata, ifu_q[0]);
                    void'(ifu_q.pop_front());
                end
            end
            if (lsu_rvalid) begin
                if (lsu_q.size() == 0) begin
                    unexp("lsu_rvalid");
                end else begin
                    chk("lsu_rdata", lsu_rdata, lsu_q[0]);
                    void'(lsu_q.pop_front());
                end
            end
            if (lsu_bvalid) begin
                if (b_exp == 0) unexp("lsu_bvalid");
                else b_exp <= b_exp - 1;
            end
            prev_ar <= bus_arvalid;
            prev_aw <= bus_awvalid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        ifu_araddr   = '0;
        ifu_arvalid  = 1'b0;
        ifu_required = 1'b0;
        lsu_araddr   = '0;
        lsu_arvalid  = 1'b0;
        lsu_awaddr   = '0;
        lsu_awvalid  = 1'b0;
        lsu_wdata    = '0;
        lsu_wstrb    = '0;

        repeat (2) step();
        chk("rst_valids", 32'({bus_arvalid, bus_awvalid, bus_wvalid,
            bus_rready, bus_bready, ifu_rvalid, lsu_rvalid, lsu_bvalid,
            grant_ifu_o}), 32'd0);
        rst = 1'b1;
        step();

        // IFU-only fetch; arready at N+2, rvalid at N+4
        ar_dly = 1;
        r_dly  = 1;
        gq.push_back('{1'b1, 32'h3000_0000});
        ifu_q.push_back(32'h0000_0413);
        ifu_araddr  = 32'h3000_0000;
        ifu_arvalid = 1'b1;
        step();
        chk("t1_arvalid_n1", 32'(bus_arvalid), 32'd1);
        chk("t1_grant_n1", 32'(grant_ifu_o), 32'd1);
        wait_for(0, "ifu_rvalid");
        step();
        ifu_arvalid = 1'b0;
        repeat (2) step();

        // LSU write; wready two cycles ahead of awready
        ar_dly = 0;
        r_dly  = 0;
        aw_dly = 2;
        w_dly  = 0;
        b_dly  = 1;
        gq.push_back('{1'b0, 32'h8000_0010});
        wq.push_back('{32'hDEAD_BEEF, 4'hF});
        b_exp       = b_exp + 1;
        lsu_awaddr  = 32'h8000_0010;
        lsu_wdata   = 32'hDEAD_BEEF;
        lsu_wstrb   = 4'hF;
        lsu_awvalid = 1'b1;
        step();
        chk("t3_aw_w_raised", 32'({bus_awvalid, bus_wvalid}), 32'd3);
        step();
        chk("t3_w_dropped", 32'({bus_awvalid, bus_wvalid}), 32'd2);
        wait_for(2, "lsu_bvalid");
        step();
        lsu_awvalid = 1'b0;
        repeat (3) step();
        aw_dly = 0;
        b_dly  = 0;

        // Locked two-beat refill with an LSU load waiting behind it
        gq.push_back('{1'b1, 32'h3000_0100});
        gq.push_back('{1'b1, 32'h3000_0104});
        gq.push_back('{1'b0, 32'h8000_0020});
        fork
            begin
                ifu_required = 1'b1;
                ifu_rd(32'h3000_0100, 32'h0000_0093);
                repeat (2) step();
                ifu_rd(32'h3000_0104, 32'h0010_0113);
                ifu_required = 1'b0;
            end
            begin
                repeat (2) step();
                lsu_rd(32'h8000_0020, 32'h1234_5678);
            end
        join
        repeat (2) step();

        // Starvation: continuous LSU loads, IFU waiting
        for (int i = 0; i < 4; i++)
            gq.push_back('{1'b0, 32'h8000_1000 + 32'(4 * i)});
        gq.push_back('{1'b1, 32'h3000_0000});
        for (int i = 4; i < 8; i++)
            gq.push_back('{1'b0, 32'h8000_1000 + 32'(4 * i)});
        gq.push_back('{1'b1, 32'h3000_0100});
        fork
            begin
                for (int i = 0; i < 8; i++)
                    lsu_rd(32'h8000_1000 + 32'(4 * i),
                           rd_table(32'h8000_1000 + 32'(4 * i)));
            end
            begin
                ifu_rd(32'h3000_0000, 32'h0000_0413);
                ifu_rd(32'h3000_0100, 32'h0000_0093);
            end
        join
        repeat (2) step();

        // Same-cycle IFU and LSU: LSU first (starve count cleared)
        gq.push_back('{1'b0, 32'h8000_0020});
        gq.push_back('{1'b1, 32'h3000_0000});
        fork
            lsu_rd(32'h8000_0020, 32'h1234_5678);
            ifu_rd(32'h3000_0000, 32'h0000_0413);
        join
        repeat (2) step();

        // Reset while LSU_R waits; late rvalid must be ignored
        r_dly = 6;
        gq.push_back('{1'b0, 32'h8000_0040});
        lsu_araddr  = 32'h8000_0040;
        lsu_arvalid = 1'b1;
        wait_for(3, "lsu_r_state");
        rst = 1'b0;
        #1;
        chk("t6_rst_valids", 32'({bus_arvalid, bus_awvalid, bus_wvalid,
            bus_rready, bus_bready, ifu_rvalid, lsu_rvalid, lsu_bvalid,
            grant_ifu_o}), 32'd0);
        lsu_arvalid = 1'b0;
        step();
        rst = 1'b1;
        wait_for(4, "late_rvalid");
        chk("t6_late_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
        chk("t6_late_rready", 32'(bus_rready), 32'd0);
        repeat (3) step();

        chk("gq_left", 32'(gq.size()), 32'd0);
        chk("ifu_q_left", 32'(ifu_q.size()), 32'd0);
        chk("lsu_q_left", 32'(lsu_q.size()), 32'd0);
        chk("wq_left", 32'(wq.size()), 32'd0);
        chk("b_left", 32'(b_exp), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
